// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rv_pkg
//  Brief   : Shared types for the ready/valid register-interface initiator.
//  Revision: 1.0
// ============================================================================
package rv_pkg;

  typedef enum logic [1:0] {
    WACK  = 2'd0,
    RDATA = 2'd1,
    EVENT = 2'd2
  } rsp_kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } init_state_e;

  // Counter width able to hold 0..cycles; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module  : rv_timeout_counter
//  Brief   : Saturating per-transaction cycle counter with expiry flag.
//  Revision: 1.0
// ============================================================================
module rv_timeout_counter
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_count
      localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;

      always_comb begin
        count_d = count_q;
        if (clear_i) begin
          count_d = '0;
        end else if (enable_i && (count_q != {CW{1'b1}})) begin
          count_d = count_q + 1'b1;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      // Expiry is only meaningful in a cycle that is itself counting.
      assign expired_o = enable_i && (count_q == C_LAST);
    end else begin : g_never
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rv_initiator.sv
`default_nettype none
// ============================================================================
//  Module  : rv_initiator
//  Brief   : Command-to-register-port initiator with one response per command,
//            per-transaction timeout and forwarding of unsolicited read data.
//  Revision: 1.0
// ============================================================================
module rv_initiator
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_kind_o,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  write_enable_o,
  output logic                  write_valid_o,
  input  logic                  write_ready_i,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  read_enable_o,
  output logic                  read_ready_o,
  input  logic                  read_valid_i,
  input  logic [DATA_WIDTH-1:0] read_data_i
);

  init_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  active_q, active_d;
  logic                  rsp_valid_q, rsp_valid_d;
  rsp_kind_e             rsp_kind_q, rsp_kind_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic rsp_full;
  logic cmd_hs;
  logic wr_hs;
  logic rd_hs;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  assign rsp_full = rsp_valid_q;

  // active_q keeps the ready/enable outputs low while reset is applied.
  assign cmd_ready_o    = active_q && (state_q == IDLE) && !rsp_full && !read_valid_i;
  assign read_ready_o   = active_q && (((state_q == IDLE) && !rsp_full) || (state_q == READ));
  assign read_enable_o  = active_q && (!rsp_full || (state_q == READ));
  assign write_valid_o  = (state_q == WRITE);
  assign write_enable_o = (state_q == WRITE);
  assign write_data_o   = (state_q == WRITE) ? data_q : '0;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_kind_o  = rsp_kind_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

  assign cmd_hs = cmd_valid_i && cmd_ready_o;
  assign wr_hs  = write_valid_o && write_ready_i;
  assign rd_hs  = read_valid_i && read_ready_o;

  assign cnt_enable = ((state_q == WRITE) && !write_ready_i) ||
                      ((state_q == READ) && !read_valid_i);

  rv_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (cnt_clear),
    .enable_i (cnt_enable),
    .expired_o(cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    active_d    = 1'b1;
    rsp_valid_d = rsp_valid_q;
    rsp_kind_d  = rsp_kind_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    cnt_clear   = 1'b0;

    if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Unsolicited data takes the buffer; a simultaneous command waits.
        if (rd_hs) begin
          rsp_valid_d = 1'b1;
          rsp_kind_d  = EVENT;
          rsp_err_d   = 1'b0;
          rsp_data_d  = read_data_i;
        end else if (cmd_hs) begin
          data_d    = cmd_data_i;
          cnt_clear = 1'b1;
          state_d   = cmd_write_i ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_hs) begin
          rsp_valid_d = 1'b1;
          rsp_kind_d  = WACK;
          rsp_err_d   = 1'b0;
          rsp_data_d  = data_q;
          state_d     = IDLE;
        end else if (cnt_expired) begin
          rsp_valid_d = 1'b1;
          rsp_kind_d  = WACK;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = IDLE;
        end
      end
      READ: begin
        if (rd_hs) begin
          rsp_valid_d = 1'b1;
          rsp_kind_d  = RDATA;
          rsp_err_d   = 1'b0;
          rsp_data_d  = read_data_i;
          state_d     = IDLE;
        end else if (cnt_expired) begin
          rsp_valid_d = 1'b1;
          rsp_kind_d  = RDATA;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      data_q      <= '0;
      active_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_kind_q  <= WACK;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      active_q    <= active_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_kind_q  <= rsp_kind_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
`default_nettype wire
